// File: rtl/powerup_pkg.sv
// Shared types, slot table and slot-selection helper for the mushroom power-up scheduler.
package powerup_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    WAIT   = 2'd2
  } state_t;

  localparam int         NUM_SLOTS = 5;
  localparam logic [7:0] LFSR_SEED = 8'hA5;

  localparam logic [9:0] SLOT_X [NUM_SLOTS] = '{10'd320, 10'd180, 10'd461, 10'd30,  10'd610};
  localparam logic [9:0] SLOT_Y [NUM_SLOTS] = '{10'd240, 10'd249, 10'd249, 10'd400, 10'd400};

  // Fold 0..7 onto 0..4, then step past the previous slot so a spawn never repeats in place.
  function automatic logic [2:0] pick_slot(input logic [2:0] rnd, input logic [2:0] prev);
    logic [2:0] cand;
    if (rnd >= 3'd5) begin
      cand = rnd - 3'd5;
    end else begin
      cand = rnd;
    end
    if (cand == prev) begin
      if (cand == 3'd4) begin
        pick_slot = 3'd0;
      end else begin
        pick_slot = cand + 3'd1;
      end
    end else begin
      pick_slot = cand;
    end
  endfunction

endpackage

// File: rtl/powerup_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1); only the low three state bits leave the block.
module powerup_lfsr8
  import powerup_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  output logic [2:0] rand_bits
);

  logic [7:0] lfsr_r;
  logic       feedback_s;

  assign feedback_s = lfsr_r[7] ^ lfsr_r[5] ^ lfsr_r[4] ^ lfsr_r[3];

  // Shift register advancing every clock, reset to the seed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_r <= LFSR_SEED;
    end else begin
      lfsr_r <= {lfsr_r[6:0], feedback_s};
    end
  end

  assign rand_bits = lfsr_r[2:0];

endmodule

// File: rtl/powerup_scheduler.sv
// Mushroom power-up sequencer: spawn slot choice, pickup arbitration, effect and respawn timers.
// POWERUP_ROUND_ROBIN_EN selects round-robin tie arbitration; otherwise P1 always wins ties.
module powerup_scheduler
  import powerup_pkg::*;
#(
  parameter logic [8:0] RESPAWN_FRAMES = 9'd180,
  parameter logic [8:0] EFFECT_FRAMES  = 9'd300
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       start,
  input  logic       reset_round,
  input  logic       collision_p1,
  input  logic       collision_p2,
  output logic       spawn_valid,
  output logic [9:0] mushroom_x,
  output logic [9:0] mushroom_y,
  output logic [2:0] slot_idx,
  output logic       grant_p1,
  output logic       grant_p2,
  output logic       effect_p1,
  output logic       effect_p2
);

  state_t     state_r, state_s;
  logic [2:0] frame_sync_r;
  logic       frame_tick_s;
  logic [2:0] rand_bits_s;
  logic [8:0] effect_cnt_r, effect_cnt_s;
  logic [8:0] respawn_cnt_r, respawn_cnt_s;
  logic       owner_p2_r, owner_p2_s;
  logic       p2_wins_s;
  logic       grant_p1_s, grant_p2_s;
  logic       select_s;
  logic [2:0] slot_s;
  logic [2:0] slot_idx_r;
  logic [9:0] mushroom_x_r, mushroom_y_r;
  logic       spawn_valid_r, grant_p1_r, grant_p2_r, effect_p1_r, effect_p2_r;

  powerup_lfsr8 u_lfsr (
    .clk       (Clk),
    .rst       (Reset),
    .rand_bits (rand_bits_s)
  );

  // Two-flop synchronizer plus an edge-history flop for rising-edge detection.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      frame_sync_r <= 3'b000;
    end else begin
      frame_sync_r <= {frame_sync_r[1:0], frame_clk};
    end
  end

  assign frame_tick_s = frame_sync_r[1] & ~frame_sync_r[2];

`ifdef POWERUP_ROUND_ROBIN_EN
  logic last_grant_p2_r;

  // Remembers the most recent winner so a tie goes to the other player.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      last_grant_p2_r <= 1'b1;
    end else if (grant_p1_s || grant_p2_s) begin
      last_grant_p2_r <= grant_p2_s;
    end
  end

  assign p2_wins_s = collision_p2 & (~collision_p1 | ~last_grant_p2_r);
`else
  assign p2_wins_s = collision_p2 & ~collision_p1;
`endif

  // Next-state, counter and grant decisions; a round clear overrides everything.
  always_comb begin
    state_s       = state_r;
    effect_cnt_s  = effect_cnt_r;
    respawn_cnt_s = respawn_cnt_r;
    owner_p2_s    = owner_p2_r;
    grant_p1_s    = 1'b0;
    grant_p2_s    = 1'b0;
    select_s      = 1'b0;
    if (reset_round) begin
      state_s       = IDLE;
      effect_cnt_s  = 9'd0;
      respawn_cnt_s = 9'd0;
    end else begin
      if ((state_r != IDLE) && frame_tick_s && (effect_cnt_r != 9'd0)) begin
        effect_cnt_s = effect_cnt_r - 9'd1;
      end else begin
        effect_cnt_s = effect_cnt_r;
      end
      case (state_r)
        IDLE: begin
          if (start) begin
            state_s  = ACTIVE;
            select_s = 1'b1;
          end else begin
            state_s = IDLE;
          end
        end
        ACTIVE: begin
          // A claim reloads both timers, so a coincident frame tick is discarded.
          if (collision_p1 || collision_p2) begin
            grant_p1_s    = ~p2_wins_s;
            grant_p2_s    = p2_wins_s;
            owner_p2_s    = p2_wins_s;
            effect_cnt_s  = EFFECT_FRAMES;
            respawn_cnt_s = RESPAWN_FRAMES;
            state_s       = WAIT;
          end else begin
            state_s = ACTIVE;
          end
        end
        WAIT: begin
          if (frame_tick_s) begin
            if (respawn_cnt_r == 9'd1) begin
              state_s  = ACTIVE;
              select_s = 1'b1;
            end else begin
              respawn_cnt_s = respawn_cnt_r - 9'd1;
            end
          end else begin
            state_s = WAIT;
          end
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end
  end

  assign slot_s = select_s ? pick_slot(rand_bits_s, slot_idx_r) : slot_idx_r;

  // State, counters and every output are registered from the next-state values.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_r       <= IDLE;
      effect_cnt_r  <= 9'd0;
      respawn_cnt_r <= 9'd0;
      owner_p2_r    <= 1'b0;
      slot_idx_r    <= 3'd0;
      mushroom_x_r  <= SLOT_X[0];
      mushroom_y_r  <= SLOT_Y[0];
      spawn_valid_r <= 1'b0;
      grant_p1_r    <= 1'b0;
      grant_p2_r    <= 1'b0;
      effect_p1_r   <= 1'b0;
      effect_p2_r   <= 1'b0;
    end else begin
      state_r       <= state_s;
      effect_cnt_r  <= effect_cnt_s;
      respawn_cnt_r <= respawn_cnt_s;
      owner_p2_r    <= owner_p2_s;
      spawn_valid_r <= (state_s == ACTIVE);
      grant_p1_r    <= grant_p1_s;
      grant_p2_r    <= grant_p2_s;
      effect_p1_r   <= (effect_cnt_s != 9'd0) & ~owner_p2_s;
      effect_p2_r   <= (effect_cnt_s != 9'd0) & owner_p2_s;
      if (select_s) begin
        slot_idx_r   <= slot_s;
        mushroom_x_r <= SLOT_X[slot_s];
        mushroom_y_r <= SLOT_Y[slot_s];
      end
    end
  end

  assign spawn_valid = spawn_valid_r;
  assign mushroom_x  = mushroom_x_r;
  assign mushroom_y  = mushroom_y_r;
  assign slot_idx    = slot_idx_r;
  assign grant_p1    = grant_p1_r;
  assign grant_p2    = grant_p2_r;
  assign effect_p1   = effect_p1_r;
  assign effect_p2   = effect_p2_r;

endmodule

// File: tb/tb_powerup_scheduler.sv
// Self-checking bench for powerup_scheduler with RESPAWN_FRAMES=3, EFFECT_FRAMES=4 against a mode/countdown model.
module tb_powerup_scheduler;

  logic       Clk = 1'b0;
  logic       Reset, frame_clk, start, reset_round, collision_p1, collision_p2;
  logic       spawn_valid, grant_p1, grant_p2, effect_p1, effect_p2;
  logic [9:0] mushroom_x, mushroom_y;
  logic [2:0] slot_idx;

  int checks = 0;
  int errors = 0;

  // Reference model: mode 0=idle 1=mushroom visible 2=waiting; owner 1/2; last winner 1/2.
  int   m_mode, m_eff, m_resp, m_owner, m_last;
  bit   m_spawned;
  logic [2:0] slot_before;
  logic exp_g1, exp_g2, g1, g2, g1_after, g2_after;
  logic [9:0] tab_x [5] = '{10'd320, 10'd180, 10'd461, 10'd30,  10'd610};
  logic [9:0] tab_y [5] = '{10'd240, 10'd249, 10'd249, 10'd400, 10'd400};

  powerup_scheduler #(.RESPAWN_FRAMES(9'd3), .EFFECT_FRAMES(9'd4)) dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .start(start), .reset_round(reset_round),
    .collision_p1(collision_p1), .collision_p2(collision_p2), .spawn_valid(spawn_valid),
    .mushroom_x(mushroom_x), .mushroom_y(mushroom_y), .slot_idx(slot_idx),
    .grant_p1(grant_p1), .grant_p2(grant_p2), .effect_p1(effect_p1), .effect_p2(effect_p2)
  );

  always #5 Clk = ~Clk;

  task automatic m_reset();
    m_mode = 0; m_eff = 0; m_resp = 0; m_owner = 0; m_last = 2; m_spawned = 0;
    exp_g1 = 1'b0; exp_g2 = 1'b0;
  endtask

  // Drive one collision cycle; capture the grant pulse and the cycle after it, then update the model.
  task automatic collide(input logic a, input logic b);
    int w;
    collision_p1 = a; collision_p2 = b;
    @(posedge Clk); @(negedge Clk);
    g1 = grant_p1; g2 = grant_p2;
    collision_p1 = 1'b0; collision_p2 = 1'b0;
    @(posedge Clk); @(negedge Clk);
    g1_after = grant_p1; g2_after = grant_p2;
    exp_g1 = 1'b0; exp_g2 = 1'b0; m_spawned = 0;
    if (m_mode == 1 && (a || b)) begin
      if (a && b) begin
`ifdef POWERUP_ROUND_ROBIN_EN
        w = (m_last == 1) ? 2 : 1;
`else
        w = 1;
`endif
      end else begin
        w = a ? 1 : 2;
      end
      m_last = w; m_owner = w; m_eff = 4; m_resp = 3; m_mode = 2;
      exp_g1 = (w == 1); exp_g2 = (w == 2);
    end
  endtask

  // One frame_clk pulse of random width, held long enough for the tick to be consumed.
  task automatic pulse_frame();
    int hi, lo;
    hi = $urandom_range(3, 6); lo = $urandom_range(2, 4);
    slot_before = slot_idx; m_spawned = 0;
    frame_clk = 1'b1; repeat (hi) @(negedge Clk);
    frame_clk = 1'b0; repeat (lo) @(negedge Clk);
    if (m_mode != 0 && m_eff > 0) m_eff--;
    if (m_mode == 2) begin
      m_resp--;
      if (m_resp == 0) begin m_mode = 1; m_spawned = 1; end
    end
  endtask

  task automatic do_start();
    slot_before = slot_idx; m_spawned = 0;
    start = 1'b1; @(posedge Clk); @(negedge Clk); start = 1'b0;
    if (m_mode == 0) begin m_mode = 1; m_spawned = 1; end
  endtask

  task automatic do_round_reset(input logic a, input logic b);
    reset_round = 1'b1; collision_p1 = a; collision_p2 = b;
    @(posedge Clk); @(negedge Clk);
    g1 = grant_p1; g2 = grant_p2;
    reset_round = 1'b0; collision_p1 = 1'b0; collision_p2 = 1'b0;
    m_mode = 0; m_eff = 0; m_resp = 0; m_owner = 0; m_spawned = 0;
    exp_g1 = 1'b0; exp_g2 = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1; frame_clk = 1'b0; start = 1'b0; reset_round = 1'b0;
    collision_p1 = 1'b0; collision_p2 = 1'b0;
    repeat (3) @(negedge Clk);
    m_reset();
    checks++; if (spawn_valid !== 1'b0) begin errors++; $display("FAIL reset_spawn got %0b want 0", spawn_valid); end
    checks++; if (mushroom_x !== 10'd320) begin errors++; $display("FAIL reset_x got %0d want 320", mushroom_x); end
    checks++; if (mushroom_y !== 10'd240) begin errors++; $display("FAIL reset_y got %0d want 240", mushroom_y); end
    checks++; if (slot_idx !== 3'd0) begin errors++; $display("FAIL reset_slot got %0d want 0", slot_idx); end
    checks++; if ({grant_p1, grant_p2, effect_p1, effect_p2} !== 4'b0000) begin
      errors++; $display("FAIL reset_grant_effect got %b want 0000", {grant_p1, grant_p2, effect_p1, effect_p2});
    end
    Reset = 1'b0; @(negedge Clk);
  endtask

  task automatic test_first_spawn();
    do_start();
    checks++; if (spawn_valid !== 1'b1) begin errors++; $display("FAIL first_spawn got %0b want 1", spawn_valid); end
    checks++; if (slot_idx == 3'd0 || slot_idx > 3'd4) begin errors++; $display("FAIL first_slot got %0d want 1..4", slot_idx); end
    checks++; if (mushroom_x !== tab_x[slot_idx] || mushroom_y !== tab_y[slot_idx]) begin
      errors++; $display("FAIL first_xy got (%0d,%0d) want (%0d,%0d)", mushroom_x, mushroom_y, tab_x[slot_idx], tab_y[slot_idx]);
    end
  endtask

  task automatic test_claim_p1();
    collide(1'b1, 1'b0);
    checks++; if (g1 !== 1'b1 || g2 !== 1'b0) begin errors++; $display("FAIL claim_grant got %b%b want 10", g1, g2); end
    checks++; if (g1_after !== 1'b0) begin errors++; $display("FAIL claim_pulse_len got %0b want 0", g1_after); end
    checks++; if (spawn_valid !== 1'b0 || effect_p1 !== 1'b1) begin
      errors++; $display("FAIL claim_state got spawn=%0b eff1=%0b want spawn=0 eff1=1", spawn_valid, effect_p1);
    end
    for (int i = 0; i < 3; i++) begin
      pulse_frame();
      checks++; if (spawn_valid !== (m_mode == 1) || effect_p1 !== (m_owner == 1 && m_eff > 0)) begin
        errors++; $display("FAIL claim_tick%0d got spawn=%0b eff1=%0b want spawn=%0b eff1=%0b", i, spawn_valid, effect_p1,
                           m_mode == 1, m_owner == 1 && m_eff > 0);
      end
    end
    checks++; if (slot_idx === slot_before || slot_idx > 3'd4 || mushroom_x !== tab_x[slot_idx] || mushroom_y !== tab_y[slot_idx]) begin
      errors++; $display("FAIL respawn_slot got %0d (%0d,%0d) want not %0d, table xy", slot_idx, mushroom_x, mushroom_y, slot_before);
    end
  endtask

  task automatic test_transfer();
    collide(1'b0, 1'b1);
    checks++; if (g1 !== 1'b0 || g2 !== 1'b1) begin errors++; $display("FAIL transfer_grant got %b%b want 01", g1, g2); end
    checks++; if (effect_p1 !== 1'b0 || effect_p2 !== 1'b1) begin
      errors++; $display("FAIL transfer_effect got %b%b want 01", effect_p1, effect_p2);
    end
    for (int i = 0; i < 4; i++) begin
      pulse_frame();
      checks++; if (spawn_valid !== (m_mode == 1) || effect_p2 !== (m_owner == 2 && m_eff > 0) || effect_p1 !== 1'b0) begin
        errors++; $display("FAIL transfer_tick%0d got spawn=%0b eff=%b%b want spawn=%0b eff2=%0b", i, spawn_valid,
                           effect_p1, effect_p2, m_mode == 1, m_owner == 2 && m_eff > 0);
      end
    end
  endtask

  task automatic test_tie();
    collide(1'b1, 1'b1);
    checks++; if (g1 !== exp_g1 || g2 !== exp_g2 || g1 !== 1'b1) begin
      errors++; $display("FAIL tie1 got %b%b want %b%b", g1, g2, exp_g1, exp_g2);
    end
    repeat (3) pulse_frame();
    checks++; if (spawn_valid !== 1'b1) begin errors++; $display("FAIL tie_respawn got %0b want 1", spawn_valid); end
    collide(1'b1, 1'b1);
    checks++; if (g1 !== exp_g1 || g2 !== exp_g2) begin
      errors++; $display("FAIL tie2 got %b%b want %b%b", g1, g2, exp_g1, exp_g2);
    end
  endtask

  task automatic test_reset_round();
    logic [2:0] last_slot;
    pulse_frame();
    checks++; if ({effect_p1, effect_p2} !== {m_owner == 1, m_owner == 2}) begin
      errors++; $display("FAIL rr_pre_effect got %b%b want owner %0d", effect_p1, effect_p2, m_owner);
    end
    last_slot = slot_idx;
    do_round_reset(1'b0, 1'b0);
    checks++; if ({spawn_valid, g1, g2, effect_p1, effect_p2} !== 5'b0) begin
      errors++; $display("FAIL rr_clear got %b want 00000", {spawn_valid, g1, g2, effect_p1, effect_p2});
    end
    checks++; if (slot_idx !== last_slot || mushroom_x !== tab_x[last_slot] || mushroom_y !== tab_y[last_slot]) begin
      errors++; $display("FAIL rr_position got slot %0d want %0d", slot_idx, last_slot);
    end
    collide(1'b1, 1'b1);
    checks++; if ({g1, g2, spawn_valid} !== 3'b000) begin errors++; $display("FAIL rr_idle_collide got %b want 000", {g1, g2, spawn_valid}); end
    do_start();
    checks++; if (spawn_valid !== 1'b1 || slot_idx === last_slot || slot_idx > 3'd4) begin
      errors++; $display("FAIL rr_restart got spawn=%0b slot=%0d want 1, not %0d", spawn_valid, slot_idx, last_slot);
    end
    do_round_reset(1'b1, 1'b0);
    checks++; if ({g1, g2, spawn_valid} !== 3'b000) begin errors++; $display("FAIL rr_vs_collide got %b want 000", {g1, g2, spawn_valid}); end
  endtask

  task automatic test_async_reset();
    do_start();
    @(posedge Clk); #2 Reset = 1'b1; #1;
    checks++; if ({spawn_valid, grant_p1, grant_p2, effect_p1, effect_p2} !== 5'b0 || slot_idx !== 3'd0 ||
                  mushroom_x !== 10'd320 || mushroom_y !== 10'd240) begin
      errors++; $display("FAIL async_reset got spawn=%0b slot=%0d x=%0d y=%0d want 0,0,320,240", spawn_valid, slot_idx, mushroom_x, mushroom_y);
    end
    @(negedge Clk); Reset = 1'b0; m_reset(); @(negedge Clk);
    collide(1'b1, 1'b0);
    checks++; if ({g1, spawn_valid, effect_p1} !== 3'b000) begin errors++; $display("FAIL async_ignore got %b want 000", {g1, spawn_valid, effect_p1}); end
  endtask

  task automatic test_random();
    int op;
    for (int n = 0; n < 60; n++) begin
      op = $urandom_range(0, 9);
      if (op < 4) begin
        collide(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        checks++; if (g1 !== exp_g1 || g2 !== exp_g2 || g1_after !== 1'b0 || g2_after !== 1'b0) begin
          errors++; $display("FAIL rnd%0d_grant got %b%b/%b%b want %b%b/00", n, g1, g2, g1_after, g2_after, exp_g1, exp_g2);
        end
      end else if (op < 8) begin
        pulse_frame();
      end else if (op == 8) begin
        do_start();
      end else begin
        do_round_reset(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        checks++; if (g1 !== 1'b0 || g2 !== 1'b0) begin errors++; $display("FAIL rnd%0d_rr_grant got %b%b want 00", n, g1, g2); end
      end
      checks++; if (spawn_valid !== (m_mode == 1) || effect_p1 !== (m_owner == 1 && m_eff > 0) ||
                    effect_p2 !== (m_owner == 2 && m_eff > 0) || {grant_p1, grant_p2} !== 2'b00) begin
        errors++; $display("FAIL rnd%0d_state op=%0d got spawn=%0b eff=%b%b want spawn=%0b eff=%b%b", n, op, spawn_valid,
                           effect_p1, effect_p2, m_mode == 1, m_owner == 1 && m_eff > 0, m_owner == 2 && m_eff > 0);
      end
      if (m_spawned) begin
        checks++; if (slot_idx === slot_before || slot_idx > 3'd4 || mushroom_x !== tab_x[slot_idx] || mushroom_y !== tab_y[slot_idx]) begin
          errors++; $display("FAIL rnd%0d_slot got %0d (%0d,%0d) prev %0d", n, slot_idx, mushroom_x, mushroom_y, slot_before);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_spawn();
    test_claim_p1();
    test_transfer();
    test_tie();
    test_reset_round();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
